diffe_top: RTL and testbench

- Diffie-Hellman key-exchange engine.
- On a start request it captures generator G, modulus P and private keys X (party A) and Y (party B).
- It computes both public keys A = G^X mod P and B = G^Y mod P, then the shared secret K = B^X mod P (equal to A^Y mod P).
- Top-level block; the three 16-bit results are packed into one 48-bit output register that holds until the next computation completes.

---
 rtl/diffe_top.sv | 121 ++++++++++++
 tb/tb_diffe_top.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/diffe_top.sv
// rtl/diffe_top.sv - Diffie-Hellman key-exchange engine (public keys A, B and shared secret K)
module diffe_top #(
  parameter int DW = 32,
  parameter int FW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ST,
  input  logic [DW-1:0] G,
  input  logic [DW-1:0] P,
  input  logic [DW-1:0] Y,
  input  logic [DW-1:0] X,
  output logic [3*FW-1:0] OUT
);

  typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;

  state_t        state;
  logic          st_q;
  logic [DW-1:0] p, x;
  logic [DW-1:0] ex, ey, ek;
  logic [DW-1:0] base_a, base_b, base_k;
  logic [DW-1:0] r_a, r_b, r_k;
  logic          start;

  // (a*b) mod m on the full double-width product; a zero modulus yields 0
  function automatic logic [DW-1:0] mulmod(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b,
                                           input logic [DW-1:0] m);
    logic [2*DW-1:0] prod;
    prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    if (m == '0) return '0;
    return DW'(prod % {{DW{1'b0}}, m});
  endfunction

  // a mod m, with a zero modulus yielding 0
  function automatic logic [DW-1:0] modred(input logic [DW-1:0] a,
                                           input logic [DW-1:0] m);
    if (m == '0) return '0;
    return a % m;
  endfunction

  // 1 mod m: 1 for m >= 2, otherwise 0
  function automatic logic [DW-1:0] one_mod(input logic [DW-1:0] m);
    return {{(DW-1){1'b0}}, (m > DW'(1))};
  endfunction

  assign start = ST & ~st_q;

  // Sequencer plus the three square-and-multiply engines (A and B in parallel, then K)
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      st_q   <= 1'b0;
      p      <= '0;
      x      <= '0;
      ex     <= '0;
      ey     <= '0;
      ek     <= '0;
      base_a <= '0;
      base_b <= '0;
      base_k <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_k    <= '0;
      OUT    <= '0;
    end else begin
      st_q <= ST;
      case (state)
        IDLE: begin
          if (start) begin
            p      <= P;
            x      <= X;
            ex     <= X;
            ey     <= Y;
            base_a <= modred(G, P);
            base_b <= modred(G, P);
            r_a    <= one_mod(P);
            r_b    <= one_mod(P);
            state  <= PH1;
          end
        end
        PH1: begin
          if (ex == '0 && ey == '0) begin
            // B's public key becomes the base of the shared-secret engine
            r_k    <= one_mod(p);
            base_k <= r_b;
            ek     <= x;
            state  <= PH2;
          end else begin
            if (ex != '0) begin
              if (ex[0]) r_a <= mulmod(r_a, base_a, p);
              base_a <= mulmod(base_a, base_a, p);
              ex     <= ex >> 1;
            end
            if (ey != '0) begin
              if (ey[0]) r_b <= mulmod(r_b, base_b, p);
              base_b <= mulmod(base_b, base_b, p);
              ey     <= ey >> 1;
            end
          end
        end
        PH2: begin
          if (ek == '0) begin
            state <= DONE;
          end else begin
            if (ek[0]) r_k <= mulmod(r_k, base_k, p);
            base_k <= mulmod(base_k, base_k, p);
            ek     <= ek >> 1;
          end
        end
        DONE: begin
          OUT   <= {r_a[FW-1:0], r_b[FW-1:0], r_k[FW-1:0]};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_diffe_top.sv
// tb/tb_diffe_top.sv - self-checking bench for diffe_top against a modular-exponentiation model
module tb_diffe_top;

  localparam int DW = 32;
  localparam int FW = 16;

  logic            CLK = 1'b0;
  logic            RST;
  logic            ST;
  logic [DW-1:0]   G, P, Y, X;
  logic [3*FW-1:0] OUT;

  int checks = 0;
  int errors = 0;

  logic [3*FW-1:0] last_exp;

  diffe_top #(.DW(DW), .FW(FW)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .G(G), .P(P), .Y(Y), .X(X), .OUT(OUT)
  );

  always #5 CLK = ~CLK;

  // Reference: left-to-right binary exponentiation with plain 64-bit arithmetic
  function automatic longint unsigned modexp(input longint unsigned g,
                                             input longint unsigned e,
                                             input longint unsigned m);
    longint unsigned r, b;
    if (m < 2) return 0;
    r = 1;
    b = g % m;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * b) % m;
    end
    return r;
  endfunction

  function automatic logic [3*FW-1:0] model(input logic [DW-1:0] g, input logic [DW-1:0] p,
                                            input logic [DW-1:0] x, input logic [DW-1:0] y);
    longint unsigned a, b, k;
    logic [3*FW-1:0] res;
    a = modexp(g, x, p);
    b = modexp(g, y, p);
    k = modexp(b, x, p);
    res = {a[FW-1:0], b[FW-1:0], k[FW-1:0]};
    return res;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [3*FW-1:0] obs, input logic [3*FW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drop ST, present inputs, raise ST; then scramble inputs and pulse ST mid-run (both ignored)
  task automatic launch(input logic [DW-1:0] g, input logic [DW-1:0] p,
                        input logic [DW-1:0] x, input logic [DW-1:0] y);
    ST = 1'b0;
    cyc(1);
    G = g; P = p; X = x; Y = y;
    ST = 1'b1;
    cyc(1);
    ST = 1'b0;
    G = $urandom; P = $urandom; X = $urandom; Y = $urandom;
    cyc(1);
    ST = 1'b1;
  endtask

  task automatic run_case(input string tag, input logic [DW-1:0] g, input logic [DW-1:0] p,
                          input logic [DW-1:0] x, input logic [DW-1:0] y);
    launch(g, p, x, y);
    cyc(78);
    last_exp = model(g, p, x, y);
    check(tag, OUT, last_exp);
  endtask

  initial begin
    logic [DW-1:0] rg, rp, rx, ry;
    longint unsigned ka;

    RST = 1'b0; ST = 1'b0;
    G = 17; P = 5; X = 6; Y = 8;
    cyc(2);
    check("reset_out", OUT, '0);
    cyc(3);
    check("reset_hold", OUT, '0);
    RST = 1'b1;
    cyc(3);
    check("idle_no_start", OUT, '0);

    ST = 1'b1;
    cyc(12);
    check("case1_within_12", OUT, 48'h0004_0001_0001);
    check("case1_model", OUT, model(17, 5, 6, 8));
    cyc(30);
    check("case1_no_restart", OUT, 48'h0004_0001_0001);

    run_case("case2", 5, 23, 6, 15);
    check("case2_const", OUT, 48'h0008_0013_0002);
    ka = modexp(modexp(5, 6, 23), 15, 23);
    check("case2_k_eq_a_pow_y", {32'h0, OUT[FW-1:0]}, ka[3*FW-1:0]);

    run_case("zero_exp_x", 2, 11, 0, 3);
    check("zero_exp_const", OUT, 48'h0001_0008_0001);
    run_case("zero_exp_y", 7, 13, 5, 0);

    run_case("p_zero", 12345, 0, 77, 99);
    check("p_zero_const", OUT, '0);
    run_case("p_one", 999, 1, 12, 34);
    check("p_one_const", OUT, '0);

    for (int i = 0; i < 8; i++) begin
      rg = $urandom;
      rp = (i < 4) ? DW'($urandom_range(2, 65535)) : DW'($urandom) | 32'h1;
      rx = $urandom;
      ry = (i == 5) ? DW'($urandom_range(0, 15)) : DW'($urandom);
      run_case($sformatf("random_%0d", i), rg, rp, rx, ry);
    end

    run_case("pre_abort", 3, 1000003, 12345, 67891);
    launch(32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc(5);
    check("hold_during_run", OUT, last_exp);
    RST = 1'b0;
    #1;
    check("abort_out_zero", OUT, '0);
    ST = 1'b0;
    cyc(3);
    check("abort_hold_zero", OUT, '0);
    RST = 1'b1;
    cyc(2);
    check("post_abort_idle", OUT, '0);
    run_case("post_abort_case", 5, 23, 6, 15);
    run_case("long_run", 7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
